// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer around a single 1-bit full adder.
// Latency: start sampled at E0, bits at E1..E_WIDTH, done high in the cycle after E_WIDTH.
// Backpressure: none queued; start is only honoured in IDLE and ignored while busy.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset; aborts any operation in flight
//   start      request, sampled only while idle
//   op_a/op_b  WIDTH-bit operands, captured on the accepted start
//   sub        subtract select, captured on the accepted start (SUB_EN builds only)
//   busy       high whenever the sequencer is not idle
//   done       one-cycle pulse marking the result as fresh
//   result     WIDTH-bit sum, held from done until the next accepted start
//   carry_out  carry out of the MSB, same validity as result
//
// Build option: define SUB_EN to add the sub port and two's-complement subtract.

// 1-bit full adder, purely combinational.
module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  // Bit counter needs at least one bit even for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             c_q;
  logic [CW-1:0]    cnt;

  logic             add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] s_next;

  adder u_adder (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Sum register shifted right with the new bit entering at the MSB.
  // Written as shift/or so it stays legal when WIDTH=1.
  always_comb begin
    s_next = '0;
    s_next = (s_sr >> 1) | (WIDTH'(add_sum) << (WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      s_sr      <= '0;
      c_q       <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr <= op_a;
`ifdef SUB_EN
            // a - b = a + ~b + 1: invert b and seed the carry with 1.
            b_sr <= sub ? ~op_b : op_b;
            c_q  <= sub;
`else
            b_sr <= op_b;
            c_q  <= 1'b0;
`endif
            s_sr  <= '0;
            cnt   <= CW'(WIDTH - 1);
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end

        S_RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          s_sr <= s_next;
          c_q  <= add_cout;
          if (cnt == '0) begin
            // Last bit: publish the completed word; result is untouched before this.
            result    <= s_next;
            carry_out <= add_cout;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, co8;
  logic [7:0] r8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1, co1;
  logic [0:0] r1;

`ifdef SUB_EN
  logic       sub8, sub1;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Model of the held result/carry per instance.
  int unsigned m_r8, m_c8, m_r1, m_c1;

  serial_add_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start8),
    .op_a      (a8),
    .op_b      (b8),
`ifdef SUB_EN
    .sub       (sub8),
`endif
    .busy      (busy8),
    .done      (done8),
    .result    (r8),
    .carry_out (co8)
  );

  serial_add_seq #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .op_a      (a1),
    .op_b      (b1),
`ifdef SUB_EN
    .sub       (sub1),
`endif
    .busy      (busy1),
    .done      (done1),
    .result    (r1),
    .carry_out (co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of test, required end before 400000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_busy(input int w);
    return (w == 8) ? 32'(busy8) : 32'(busy1);
  endfunction
  function automatic logic [31:0] rd_done(input int w);
    return (w == 8) ? 32'(done8) : 32'(done1);
  endfunction
  function automatic logic [31:0] rd_res(input int w);
    return (w == 8) ? 32'(r8) : 32'(r1);
  endfunction
  function automatic logic [31:0] rd_co(input int w);
    return (w == 8) ? 32'(co8) : 32'(co1);
  endfunction

  // Must be called at a falling edge with the target instance idle.
  // Returns at a falling edge with that instance idle again.
  task automatic op(input int w, input int unsigned a, input int unsigned b, input logic s);
    int unsigned mask, av, bv, tot, er, ec, hr, hc;
    int          k;
    logic        ss;
`ifdef SUB_EN
    ss = s;
`else
    ss = 1'b0;
    if (s) ss = 1'b0;
`endif
    mask = (w == 8) ? 32'hFF : 32'h1;
    av   = a & mask;
    bv   = b & mask;
    tot  = ss ? (av + ((~bv) & mask) + 1) : (av + bv);
    er   = tot & mask;
    ec   = (tot >> w) & 1;
    hr   = (w == 8) ? m_r8 : m_r1;
    hc   = (w == 8) ? m_c8 : m_c1;

    if (w == 8) begin
      start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0];
`ifdef SUB_EN
      sub8 = ss;
`endif
    end else begin
      start1 = 1'b1; a1 = av[0:0]; b1 = bv[0:0];
`ifdef SUB_EN
      sub1 = ss;
`endif
    end
    @(negedge clk);
    // Scramble operands after capture; the running operation must not care.
    if (w == 8) begin start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); end
    else begin start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); end
    chk($sformatf("busy_after_start_w%0d", w), rd_busy(w), 32'd1);
    chk($sformatf("held_res_in_run_w%0d", w), rd_res(w), hr);
    chk($sformatf("held_co_in_run_w%0d", w), rd_co(w), hc);

    k = 0;
    while (rd_done(w) !== 32'd1 && k < w + 4) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("done_latency_w%0d", w), k, w);
    chk($sformatf("result_w%0d_%0h_%0h_s%0d", w, av, bv, ss), rd_res(w), er);
    chk($sformatf("carry_w%0d_%0h_%0h_s%0d", w, av, bv, ss), rd_co(w), ec);
    if (w == 8) begin m_r8 = er; m_c8 = ec; end
    else begin m_r1 = er; m_c1 = ec; end

    @(negedge clk);
    chk($sformatf("done_pulse_w%0d", w), rd_done(w), 32'd0);
    chk($sformatf("idle_after_done_w%0d", w), rd_busy(w), 32'd0);
  endtask

  initial begin
    int ndone;
    int k;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
`ifdef SUB_EN
    sub8 = 1'b0; sub1 = 1'b0;
`endif
    m_r8 = 0; m_c8 = 0; m_r1 = 0; m_c1 = 0;

    repeat (2) @(negedge clk);
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_done8", 32'(done8), 32'd0);
    chk("reset_res8",  32'(r8),    32'd0);
    chk("reset_co8",   32'(co8),   32'd0);
    chk("reset_busy1", 32'(busy1), 32'd0);
    chk("reset_res1",  32'(r1),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed add cases, issued back to back.
    op(8, 32'h5A, 32'h25, 1'b0);
    chk("t1_const_res", 32'(r8), 32'h7F);
    chk("t1_const_co",  32'(co8), 32'd0);
    op(8, 32'hFF, 32'h01, 1'b0);
    chk("t2_const_res", 32'(r8), 32'h00);
    chk("t2_const_co",  32'(co8), 32'd1);
    op(8, 32'h00, 32'h00, 1'b0);
    op(1, 1, 1, 1'b0);
    chk("w1_const_res", 32'(r1), 32'd0);
    chk("w1_const_co",  32'(co1), 32'd1);
    op(1, 0, 1, 1'b0);
    op(1, 0, 0, 1'b0);

`ifdef SUB_EN
    op(8, 32'h10, 32'h01, 1'b1);
    chk("sub_const_res", 32'(r8), 32'h0F);
    chk("sub_const_co",  32'(co8), 32'd1);
    op(8, 32'h00, 32'h01, 1'b1);
    chk("sub_borrow_res", 32'(r8), 32'hFF);
    chk("sub_borrow_co",  32'(co8), 32'd0);
    op(1, 0, 1, 1'b1);
    op(1, 1, 1, 1'b1);
`endif

    // start held high through the whole operation with changing operands.
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h5A;
    ndone = 0; k = 0;
    while (busy8 === 1'b1 && k < 20) begin
      if (done8 === 1'b1) ndone++;
      @(negedge clk);
      k++;
    end
    chk("held_start_one_done", ndone, 32'd1);
    chk("held_start_res", 32'(r8), 32'h33);
    chk("held_start_co",  32'(co8), 32'd0);
    // start is still high in IDLE: it is re-sampled with the new operands.
    @(negedge clk);
    chk("held_start_resampled", 32'(busy8), 32'd1);
    start8 = 1'b0;
    k = 0;
    while (done8 !== 1'b1 && k < 14) begin @(negedge clk); k++; end
    chk("resample_done_seen", 32'(done8), 32'd1);
    chk("resample_res", 32'(r8), 32'h1D);
    chk("resample_co",  32'(co8), 32'd1);
    m_r8 = 32'h1D; m_c8 = 1;
    @(negedge clk);

    // Reset pulsed in the middle of an operation.
    start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy8), 32'd0);
    chk("midreset_done", 32'(done8), 32'd0);
    chk("midreset_res",  32'(r8),    32'd0);
    chk("midreset_co",   32'(co8),   32'd0);
    m_r8 = 0; m_c8 = 0; m_r1 = 0; m_c1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    chk("midreset_no_done", ndone, 32'd0);
    op(8, 32'h03, 32'h04, 1'b0);
    chk("after_reset_res", 32'(r8), 32'h07);

    // Randomized back-to-back traffic on both widths.
    for (int i = 0; i < 24; i++) begin
      op(($urandom_range(0, 1) == 1) ? 8 : 1, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
